// File: rtl/rdp_pkg.sv
// Shared definitions for the RAM read-path blocks: FSM encoding and
// buffering credit constants used by the reader and its skid FIFO.
package rdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  localparam int FIFO_DEPTH  = 2;
  localparam int COUNT_WIDTH = 2;

  // Buffered words plus the word still returning from the RAM must fit the FIFO.
  function automatic logic credit_avail(input logic [COUNT_WIDTH-1:0] occupancy,
                                        input logic in_flight);
    return ({1'b0, occupancy} + {2'b00, in_flight}) < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO between the registered RAM read port and the stream output.
// Simultaneous push and pop are allowed in every state.
module stream_skid_fifo
  import rdp_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid
);

  logic                   wr_ptr_reg;
  logic                   rd_ptr_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic                   do_push;
  logic                   do_pop;
  logic [DATA_WIDTH-1:0]  entry_data [FIFO_DEPTH];

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != COUNT_WIDTH'(FIFO_DEPTH)) || do_pop);

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gen_entry
      logic [DATA_WIDTH-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end

      assign entry_data[gi] = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + COUNT_WIDTH'(1);
        2'b01:   count_reg <= count_reg - COUNT_WIDTH'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign out_data  = entry_data[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a burst of consecutive RAM words through a 1-cycle-latency read port
// and streams them out with valid/ready flow control.
module ram_stream_reader
  import rdp_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDRS_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRS_WIDTH-1:0] base_addrs,
  input  logic [ADDRS_WIDTH:0]   len,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_rdn,
  output logic [ADDRS_WIDTH-1:0] ram_addrs,
  input  logic [DATA_WIDTH-1:0]  ram_data,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready
);

  rd_state_t              state_reg;
  rd_state_t              state_next;
  logic [ADDRS_WIDTH-1:0] addr_reg;
  logic [ADDRS_WIDTH:0]   reads_left_reg;
  logic                   in_flight_reg;
  logic                   done_reg;
  logic                   done_next;
  logic [COUNT_WIDTH-1:0] fifo_count;
  logic                   pop;
  logic                   accept;
  logic                   zero_burst;
  logic                   last_read;
  logic                   last_beat;

  assign pop        = m_valid && m_ready;
  assign accept     = (state_reg == ST_IDLE) && start && (len != '0);
  assign zero_burst = (state_reg == ST_IDLE) && start && (len == '0);
  assign last_read  = ram_rdn && (reads_left_reg == (ADDRS_WIDTH + 1)'(1));
  // Final beat: FIFO holds one word, nothing more returning from the RAM.
  assign last_beat  = pop && (fifo_count == COUNT_WIDTH'(1)) && !in_flight_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept)    state_next = ST_READ;
      ST_READ:  if (last_read) state_next = ST_DRAIN;
      ST_DRAIN: if (last_beat) state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_rdn   = 1'b0;
    busy      = 1'b0;
    done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        done_next = zero_burst;
      end
      ST_READ: begin
        busy    = 1'b1;
        ram_rdn = !rst && (credit_avail(fifo_count, in_flight_reg) || pop);
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        done_next = last_beat;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Clearing the in-flight flag on reset drops any word still returning.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg       <= '0;
      reads_left_reg <= '0;
      in_flight_reg  <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      in_flight_reg <= ram_rdn;
      done_reg      <= done_next;
      if (accept) begin
        addr_reg       <= base_addrs;
        reads_left_reg <= len;
      end else if (ram_rdn) begin
        addr_reg       <= addr_reg + ADDRS_WIDTH'(1);
        reads_left_reg <= reads_left_reg - (ADDRS_WIDTH + 1)'(1);
      end
    end
  end

  assign ram_addrs = addr_reg;
  assign done      = done_reg;

  stream_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_flight_reg),
    .push_data(ram_data),
    .pop      (pop),
    .count    (fifo_count),
    .out_data (m_data),
    .out_valid(m_valid)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: table of bursts, random bursts and hand-written
// reset/zero-length sequences, checked against an address-order word model.
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MODE_FULL   = 0;
  localparam int MODE_TOGGLE = 1;
  localparam int MODE_RAND   = 2;

  typedef struct {
    int base;
    int len;
    int mode;
    int exp_first;
    int exp_last;
    int exp_cycles;
    int extra_cyc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addrs = '0;
  logic [AW:0]   burst_len = '0;
  logic          busy;
  logic          done;
  logic          ram_rdn;
  logic [AW-1:0] ram_addrs;
  logic [DW-1:0] ram_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor-owned bookkeeping.
  int            cyc = 0;
  int            outstanding = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  int            got_q[$];
  int            addr_q[$];
  int            rdn_cyc_q[$];
  int            done_count = 0;
  int            done_cyc = 0;
  int            credit_viol = 0;
  int            stall_viol = 0;
  int            done_busy_viol = 0;

  vec_t vecs[8];

  always #5 clk = ~clk;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDRS_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addrs(base_addrs),
    .len       (burst_len),
    .busy      (busy),
    .done      (done),
    .ram_rdn   (ram_rdn),
    .ram_addrs (ram_addrs),
    .ram_data  (ram_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  // Behavioural RAM, mem[i] = 0x10 + i, one cycle read latency.
  always @(posedge clk) begin
    if (ram_rdn) ram_data <= 8'h10 + {4'h0, ram_addrs};
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      outstanding <= 0;
      stall_prev  <= 1'b0;
    end else begin
      if (ram_rdn) begin
        addr_q.push_back(int'(ram_addrs));
        rdn_cyc_q.push_back(cyc);
        if (outstanding >= 2 && !(m_valid && m_ready)) credit_viol <= credit_viol + 1;
      end
      if (m_valid && m_ready) got_q.push_back(int'(m_data));
      if (stall_prev && (!m_valid || m_data != data_prev)) stall_viol <= stall_viol + 1;
      if (done) begin
        done_count <= done_count + 1;
        done_cyc   <= cyc;
        if (busy) done_busy_viol <= done_busy_viol + 1;
      end
      outstanding <= outstanding + (ram_rdn ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      stall_prev  <= m_valid && !m_ready;
      data_prev   <= m_data;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int j);
    if (mode == MODE_FULL) return 1'b1;
    if (mode == MODE_TOGGLE) return (j % 6 == 0) || (j % 6 == 3) || (j % 6 == 5);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_burst(input vec_t v, input bit rel, input string tag);
    int g0, a0, d0, cv0, sv0, dv0, j, n_got, n_rd;
    int exp_w[$];
    g0 = got_q.size(); a0 = addr_q.size(); d0 = done_count;
    cv0 = credit_viol; sv0 = stall_viol; dv0 = done_busy_viol;
    for (int i = 0; i < v.len; i++) exp_w.push_back('h10 + ((v.base + i) % 16));
    @(posedge clk); #1;
    if (rel) rst = 1'b0;
    start = 1'b1; base_addrs = AW'(v.base); burst_len = (AW + 1)'(v.len); m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    while (done_count == d0 && j < 500) begin
      m_ready = ready_for(v.mode, j);
      if (j == v.extra_cyc) begin
        start = 1'b1; base_addrs = 4'h5; burst_len = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      j++;
    end
    start = 1'b0; m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_got = got_q.size() - g0;
    n_rd  = addr_q.size() - a0;
    check($sformatf("%s done_pulses", tag), done_count - d0, 1);
    check($sformatf("%s beats", tag), n_got, v.len);
    check($sformatf("%s reads", tag), n_rd, v.len);
    for (int k = 0; k < v.len && k < n_got; k++)
      check($sformatf("%s word%0d", tag, k), got_q[g0 + k], exp_w[k]);
    for (int k = 0; k < v.len && k < n_rd; k++)
      check($sformatf("%s addr%0d", tag, k), addr_q[a0 + k], (v.base + k) % 16);
    if (n_got >= v.len) begin
      check($sformatf("%s first_word", tag), got_q[g0], v.exp_first);
      check($sformatf("%s last_word", tag), got_q[g0 + v.len - 1], v.exp_last);
    end
    if (v.exp_cycles >= 0 && n_rd > 0)
      check($sformatf("%s cycles", tag), done_cyc - rdn_cyc_q[a0], v.exp_cycles);
    check($sformatf("%s credit_rule", tag), credit_viol - cv0, 0);
    check($sformatf("%s stall_stable", tag), stall_viol - sv0, 0);
    check($sformatf("%s done_busy", tag), done_busy_viol - dv0, 0);
    $display("burst %s base=0x%0h len=%0d mode=%0d beats=%0d", tag, v.base, v.len, v.mode, n_got);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, d0, g0, j;
    vec_t v;

    vecs[0] = '{3,  4,  MODE_FULL,   'h13, 'h16, 6,  -1};
    vecs[1] = '{14, 4,  MODE_FULL,   'h1E, 'h11, 6,  -1};
    vecs[2] = '{0,  5,  MODE_TOGGLE, 'h10, 'h14, -1, -1};
    vecs[3] = '{15, 1,  MODE_FULL,   'h1F, 'h1F, 3,  -1};
    vecs[4] = '{0,  16, MODE_FULL,   'h10, 'h1F, 18, -1};
    vecs[5] = '{7,  9,  MODE_RAND,   'h17, 'h1F, -1, -1};
    vecs[6] = '{12, 16, MODE_TOGGLE, 'h1C, 'h1B, -1, -1};
    vecs[7] = '{0,  3,  MODE_FULL,   'h10, 'h12, 5,  2};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset ram_rdn", ram_rdn, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset ram_addrs", ram_addrs, 0);
    $display("reset state checked");

    // First burst starts in the very cycle rst is released.
    for (int i = 0; i < 8; i++) run_burst(vecs[i], (i == 0), $sformatf("vec%0d", i));

    // Zero-length burst.
    @(posedge clk); #1;
    a0 = addr_q.size(); d0 = done_count;
    start = 1'b1; burst_len = '0; base_addrs = 4'h9;
    @(negedge clk);
    check("zero busy_at_start", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero done_pulse", done, 1);
    check("zero busy_during_done", busy, 0);
    @(posedge clk);
    @(negedge clk); #1;
    check("zero done_cleared", done, 0);
    check("zero done_count", done_count - d0, 1);
    check("zero no_reads", addr_q.size() - a0, 0);
    $display("zero-length burst checked");

    // Reset in the middle of a long burst.
    @(posedge clk); #1;
    g0 = got_q.size(); d0 = done_count;
    start = 1'b1; base_addrs = 4'h0; burst_len = 5'd16; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    while (got_q.size() - g0 < 3 && j < 100) begin
      @(posedge clk); #1;
      j++;
    end
    check("rstmid beats_before", got_q.size() - g0, 3);
    rst = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("rstmid m_valid", m_valid, 0);
    check("rstmid busy", busy, 0);
    check("rstmid done", done, 0);
    repeat (4) @(posedge clk);
    #1;
    check("rstmid no_done", done_count - d0, 0);
    check("rstmid no_more_beats", got_q.size() - g0, 3);
    $display("mid-burst reset checked");
    v = '{8, 2, MODE_FULL, 'h18, 'h19, 4, -1};
    run_burst(v, 1'b0, "after_rst");

    // Random bursts against the address-order model.
    for (int r = 0; r < 20; r++) begin
      v.base = $urandom_range(0, 15);
      v.len  = $urandom_range(1, 16);
      v.mode = $urandom_range(0, 2);
      v.exp_first  = 'h10 + v.base;
      v.exp_last   = 'h10 + ((v.base + v.len - 1) % 16);
      v.exp_cycles = (v.mode == MODE_FULL) ? v.len + 2 : -1;
      v.extra_cyc  = -1;
      run_burst(v, 1'b0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
